// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the memory controller: enables, zero values, length codes, FSM states.
// Also holds the length decode and byte-lane select helpers.
package mem_ctrl_pkg;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam logic [7:0]  ZERO_BYTE = 8'h00;

    localparam logic [1:0] LEN_BYTE = 2'b00;
    localparam logic [1:0] LEN_HALF = 2'b01;
    localparam logic [1:0] LEN_ALT  = 2'b10;
    localparam logic [1:0] LEN_WORD = 2'b11;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Index of the final byte of a transfer (byte count minus one).
    function automatic logic [1:0] len_last(input logic [1:0] len);
        case (len)
            LEN_BYTE: return 2'd0;
            LEN_HALF: return 2'd1;
            LEN_ALT:  return 2'd0;
            LEN_WORD: return 2'd3;
            default:  return 2'd0;
        endcase
    endfunction

    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbiter and sequencer sharing one byte-wide, 1-cycle-latency RAM between the
// instruction-fetch and load/store requesters; little-endian, MEM has priority.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [31:0]       if_inst_o,
    output logic              if_done_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_len_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic [31:0]       mem_rdata_o,
    output logic              mem_done_o,
    output logic [ADDR_W-1:0] addr_ram_o,
    input  logic [7:0]        d_ram_i,
    output logic [7:0]        d_ram_o,
    output logic              wr_ram_o
);

    logic [1:0]        state;
    logic [1:0]        cnt;
    logic [1:0]        last_q;
    logic              rd_cap;
    logic              own_mem;
    logic              rdy_q;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rd_data;
    logic [31:0]       rd_next;
    logic [7:0]        d_hold;
    logic [7:0]        rd_byte;
    logic [1:0]        addr_off;
    logic              last_byte;
    logic              busy;

    assign last_byte = (cnt == last_q);
    assign busy      = (state == S_READ) || (state == S_WRITE);

    // A stall leaves the RAM output pointing one byte ahead, so the byte that
    // was on d_ram_i when the stall began is parked in d_hold for the resume cycle.
    assign rd_byte = rdy_q ? d_ram_i : d_hold;
    assign rd_next = rd_data | (32'(rd_byte) << {cnt, 3'b000});

    // While capturing byte cnt, the address for byte cnt+1 is already issued;
    // the final capture cycle simply repeats the last address.
    always_comb begin
        addr_off = cnt;
        if (state == S_READ && rd_cap && !last_byte) begin
            addr_off = cnt + 2'd1;
        end
    end

    assign addr_ram_o = busy ? base_q + ADDR_W'(addr_off) : '0;
    assign d_ram_o    = (state == S_WRITE) ? byte_sel(wdata_q, cnt) : ZERO_BYTE;
    assign wr_ram_o   = (state == S_WRITE && rdy) ? ENABLE : DISABLE;
    assign if_done_o  = (state == S_DONE && !own_mem) ? ENABLE : DISABLE;
    assign mem_done_o = (state == S_DONE && own_mem) ? ENABLE : DISABLE;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            cnt         <= 2'd0;
            last_q      <= 2'd0;
            rd_cap      <= DISABLE;
            own_mem     <= DISABLE;
            rdy_q       <= DISABLE;
            if_inst_o   <= ZERO_WORD;
            mem_rdata_o <= ZERO_WORD;
        end else begin
            rdy_q <= rdy;
            if (rdy) begin
                case (state)
                    S_IDLE: begin
                        cnt    <= 2'd0;
                        rd_cap <= DISABLE;
                        if (mem_req_i) begin
                            own_mem <= ENABLE;
                            last_q  <= len_last(mem_len_i);
                            state   <= mem_we_i ? S_WRITE : S_READ;
                        end else if (if_req_i) begin
                            own_mem <= DISABLE;
                            last_q  <= len_last(LEN_WORD);
                            state   <= S_READ;
                        end
                    end
                    S_READ: begin
                        if (!rd_cap) begin
                            rd_cap <= ENABLE;
                        end else begin
                            cnt <= cnt + 2'd1;
                            if (last_byte) begin
                                state <= S_DONE;
                                if (own_mem) begin
                                    mem_rdata_o <= rd_next;
                                end else begin
                                    if_inst_o <= rd_next;
                                end
                            end
                        end
                    end
                    S_WRITE: begin
                        cnt <= cnt + 2'd1;
                        if (last_byte) begin
                            state <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Transaction data path: latched at grant, assembled during READ.
    always_ff @(posedge clk) begin
        d_hold <= rd_byte;
        if (rdy) begin
            if (state == S_IDLE) begin
                base_q  <= mem_req_i ? mem_addr_i : if_addr_i;
                wdata_q <= mem_wdata_i;
                rd_data <= ZERO_WORD;
            end else if (state == S_READ && rd_cap) begin
                rd_data <= rd_next;
            end
        end
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width for all address ports.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-low reset (0 = reset, sampled on clk rising edge).
REQ-004 SHALL have port rdy, input, 1, global ready; 0 = freeze.
REQ-005 SHALL have ports if_req_i (input, 1), if_addr_i (input, ADDR_W), if_inst_o (output, 32), if_done_o (output, 1): instruction-fetch requester.
REQ-006 SHALL have ports mem_req_i (input, 1), mem_we_i (input, 1), mem_len_i (input, 2), mem_addr_i (input, ADDR_W), mem_wdata_i (input, 32), mem_rdata_o (output, 32), mem_done_o (output, 1): load/store requester.
REQ-007 SHALL have ports addr_ram_o (output, ADDR_W), d_ram_i (input, 8), d_ram_o (output, 8), wr_ram_o (output, 1, 1 = write): byte-wide RAM.

Function
REQ-008 SHALL arbitrate the single byte-wide RAM between the IF and MEM requesters.
REQ-009 SHALL use FSM states IDLE, READ, WRITE, DONE.
REQ-010 SHALL, in IDLE, grant MEM when mem_req_i=1, else grant IF when if_req_i=1, else stay IDLE.
REQ-011 SHALL latch the granted address, direction, length and write data at grant, ignoring later requester changes until done.
REQ-012 SHALL never preempt a granted transaction.
REQ-013 SHALL decode transfer length from mem_len_i as 00=1 byte, 01=2 bytes, 11=4 bytes, 10=1 byte; IF transfers are always 4 bytes, always reads.
REQ-014 SHALL transfer bytes little-endian: byte i at latched address + i, 32-bit wrap-around (0xFFFFFFFF + 1 = 0x00000000).
REQ-015 SHALL treat the RAM as 1-cycle read latency: data for the address driven in cycle k appears on d_ram_i in cycle k+1.
REQ-016 SHALL, in READ, drive addresses in N consecutive cycles, capture byte i in the cycle after its address, then enter DONE; N-byte read = N+1 cycles in READ.
REQ-017 SHALL zero-extend read data in mem_rdata_o; sign extension is outside this block.
REQ-018 SHALL, in WRITE, drive wr_ram_o=1 with byte i of the write data at address + i for N consecutive cycles, then enter DONE.
REQ-019 SHALL, in DONE, pulse the granted requester's done output for exactly one cycle with its data valid, then return to IDLE.
REQ-020 SHALL hold if_inst_o and mem_rdata_o stable until that requester's next done.
REQ-021 SHALL ignore requests in the DONE cycle and the following IDLE cycle only if the requester's req is already low; otherwise a held req is a new request.
REQ-022 SHALL keep wr_ram_o=0 in every state except WRITE.
REQ-023 SHALL, when rdy=0, hold all state, counters and outputs and force wr_ram_o=0; operation resumes on rdy=1 without losing or duplicating bytes.
REQ-024 SHALL, when both requests arrive in the same IDLE cycle, serve MEM first and IF immediately after MEM's DONE cycle.

Reset
REQ-025 SHALL, while rst=0 at a clk edge, enter IDLE and clear the byte counter.
REQ-026 SHALL, while rst=0 at a clk edge, drive addr_ram_o=0, d_ram_o=0, wr_ram_o=0, if_done_o=0, mem_done_o=0, if_inst_o=0, mem_rdata_o=0.
REQ-027 SHALL, on reset mid-transaction, abort the transaction with no done pulse.
REQ-028 SHALL give reset priority over rdy.

Structure
REQ-029 SHALL take from macro.vh the Enable/Disable, ZeroWord/ZeroByte, length-code and FSM-state constants.
REQ-030 SHALL be one flat module using a 2-bit byte counter; no sub-module.

Verification
REQ-031 SHALL verify IF read: RAM[0x100..0x103]=13,00,00,00 with if_req at 0x100 -> if_done pulses 6 cycles after grant, if_inst_o=0x00000013.
REQ-032 SHALL verify simultaneous requests: if_req plus mem_req (load, len=11, 0x200 = AA,BB,CC,DD) in one cycle -> mem_done first with mem_rdata_o=0xDDCCBBAA, then IF is served.
REQ-033 SHALL verify store: mem_we=1, len=01, addr 0x300, wdata 0x12345678 -> RAM[0x300]=78 and RAM[0x301]=56 written, RAM[0x302] unchanged, mem_done pulses once.
REQ-034 SHALL verify wrap: 4-byte read at 0xFFFFFFFE -> addresses FFFFFFFE, FFFFFFFF, 00000000, 00000001.
REQ-035 SHALL verify stall: rdy=0 for 3 cycles mid-write -> wr_ram_o=0 throughout the stall, each byte written exactly once.
REQ-036 SHALL verify reset: rst=0 during the third byte of a read -> no done pulse, state IDLE, all outputs 0.
